// File: rtl/counter_pkg.sv
// Shared constants for the counter-lab blocks: default width, reset value
// and an all-ones helper for sizing terminal values.
package counter_pkg;

    localparam int   DEF_WIDTH = 4;
    localparam logic RST_VAL   = 1'b0;

    function automatic int all_ones(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/up_count_slice.sv
// One bit of the up counter: a flip-flop whose next state is chosen from
// reset, parallel load, forced-zero wrap, toggle, or hold.
module up_count_slice
    import counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic ld,
    input  logic load_bit,
    input  logic toggle,
    input  logic wrap,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= RST_VAL;
        else if (ld)
            q <= load_bit;
        else if (wrap)
            q <= 1'b0;
        else if (toggle)
            q <= ~q;
    end

endmodule

// File: rtl/up_counter_mod.sv
// WIDTH-bit up counter with modulus MAX, parallel load, cascadable terminal
// count and a sticky wrap flag, built from per-bit toggle slices.
module up_counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic             at_max;
    logic             wrap;
    logic [WIDTH-1:0] carry;

    // Values above MAX (reachable only via load) also count as terminal,
    // so the next enabled edge returns straight to zero.
    assign at_max = (out >= MAX_V);
    assign tc     = en & at_max;
    assign wrap   = tc & ~ld;

    // carry[i] is high when bit i should toggle: enabled and all lower bits set.
    assign carry[0] = en;

    genvar i;
    generate
        for (i = 1; i < WIDTH; i++) begin : g_carry
            assign carry[i] = carry[i-1] & out[i-1];
        end

        for (i = 0; i < WIDTH; i++) begin : g_slice
            up_count_slice u_slice (
                .clk      (clk),
                .rst      (rst),
                .ld       (ld),
                .load_bit (d[i]),
                .toggle   (carry[i]),
                .wrap     (wrap),
                .q        (out[i])
            );
        end
    endgenerate

    // A wrap on the same edge as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (rst)
            ovf <= RST_VAL;
        else if (wrap)
            ovf <= 1'b1;
        else if (clr_ovf)
            ovf <= 1'b0;
    end

endmodule

// File: tb/tb_up_counter_mod.sv
// Scoreboard bench for up_counter_mod: two instances (MAX=15 and MAX=9)
// share stimulus; a reference model queues expectations, monitors compare.
module tb_up_counter_mod;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       ld = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [3:0] d = 4'd0;

    logic [3:0] out_a, out_b;
    logic       tc_a, tc_b, ovf_a, ovf_b;

    up_counter_mod #(.WIDTH(4), .MAX(15)) dut_a (
        .clk(clk), .rst(rst), .en(en), .ld(ld), .d(d), .clr_ovf(clr_ovf),
        .out(out_a), .tc(tc_a), .ovf(ovf_a)
    );

    up_counter_mod #(.WIDTH(4), .MAX(9)) dut_b (
        .clk(clk), .rst(rst), .en(en), .ld(ld), .d(d), .clr_ovf(clr_ovf),
        .out(out_b), .tc(tc_b), .ovf(ovf_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] oa;
        logic       va;
        logic [3:0] ob;
        logic       vb;
    } st_t;

    st_t        st_q[$];
    logic [1:0] tc_q[$];

    int checks = 0;
    int errors = 0;

    int ma = 0, va = 0, mb = 0, vb = 0;
    bit known = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour written directly from the counting rules.
    function automatic int ref_out(input int o, input int m, input bit r,
                                   input bit l, input bit e, input int dv);
        if (r) return 0;
        if (l) return dv;
        if (e) return (o >= m) ? 0 : o + 1;
        return o;
    endfunction

    function automatic int ref_ovf(input int o, input int v, input int m, input bit r,
                                   input bit l, input bit e, input bit c);
        if (r) return 0;
        if (!l && e && o >= m) return 1;
        if (c) return 0;
        return v;
    endfunction

    task automatic step(input bit r, input bit e, input bit l, input int dv, input bit c);
        int na, nb;
        @(negedge clk);
        rst = r; en = e; ld = l; d = dv[3:0]; clr_ovf = c;
        if (known)
            tc_q.push_back({logic'(e && ma >= 15), logic'(e && mb >= 9)});
        na = ref_out(ma, 15, r, l, e, dv);
        nb = ref_out(mb, 9, r, l, e, dv);
        va = ref_ovf(ma, va, 15, r, l, e, c);
        vb = ref_ovf(mb, vb, 9, r, l, e, c);
        ma = na;
        mb = nb;
        if (r) known = 1'b1;
        if (known)
            st_q.push_back({ma[3:0], logic'(va[0]), mb[3:0], logic'(vb[0])});
    endtask

    // State monitor: registered outputs just after each rising edge.
    initial begin
        st_t s;
        forever begin
            @(posedge clk);
            #1;
            if (st_q.size() != 0) begin
                s = st_q.pop_front();
                chk("out_a", int'(out_a), int'(s.oa));
                chk("ovf_a", int'(ovf_a), int'(s.va));
                chk("out_b", int'(out_b), int'(s.ob));
                chk("ovf_b", int'(ovf_b), int'(s.vb));
            end
        end
    end

    // Terminal-count monitor: combinational tc once the new inputs settle.
    initial begin
        logic [1:0] t;
        forever begin
            @(negedge clk);
            #2;
            if (tc_q.size() != 0) begin
                t = tc_q.pop_front();
                chk("tc_a", int'(tc_a), int'(t[1]));
                chk("tc_b", int'(tc_b), int'(t[0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset then free count through both moduli.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        repeat (17) step(0, 1, 0, 0, 0);

        // Load priority, then a load above MAX for the MAX=9 instance.
        step(1, 0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 7, 0);
        step(0, 0, 1, 12, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);

        // Enable gating at 6.
        step(0, 0, 1, 6, 0);
        repeat (5) step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);

        // Wrap and clear on the same edge, then a lone clear.
        step(0, 0, 1, 15, 0);
        step(0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Reset overrides a simultaneous load and enable.
        step(0, 0, 1, 11, 0);
        step(1, 1, 1, 5, 0);

        for (int k = 0; k < 300; k++) begin
            step($urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 15,
                 int'($urandom_range(0, 15)),
                 $urandom_range(0, 99) < 10);
        end

        step(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("drain_st", st_q.size(), 0);
        chk("drain_tc", tc_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/up_counter_mod.md
Name: up_counter_mod

Overview:
- Synchronous WIDTH-bit up counter; complements the lab's down counter.
- Counts 0 to MAX, then wraps to 0.
- Supports parallel load, count enable, a cascadable terminal-count output and a sticky wrap flag.
- Used as the elapsed/event counter stage of the counter labs.
- Built from per-bit flip-flop slices with dataflow next-state logic, not behavioural "+1".

Parameters:
- WIDTH, 4, counter width in bits (valid range 2 to 8).
- MAX, 15, terminal value; count wraps to 0 after MAX (must satisfy 1 <= MAX <= 2^WIDTH-1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable; increments on the edge when high.
- ld  input  1  parallel load strobe.
- d  input  WIDTH  load value.
- clr_ovf  input  1  clears the sticky wrap flag.
- out  output  WIDTH  current count (registered).
- tc  output  1  terminal count; combinational; used for cascading.
- ovf  output  1  sticky wrap flag (registered).

Behaviour:
- Clock and reset:
  - Single clock domain; all state updates on the rising edge of clk.
  - rst is synchronous and active-high. On a reset edge, out=0 and ovf=0, regardless of every other input.
- Next-state priority per edge: rst > ld > en > hold.
  - ld=1: out <= d on the next edge, whether or not en is high. A load never sets ovf and never produces a wrap.
  - en=1, ld=0, out < MAX: out <= out+1. Latency is one cycle from en sampled to the new value on out.
  - en=1, ld=0, out >= MAX: out <= 0 (the wrap event), and ovf <= 1.
    - out >= MAX is reachable when d > MAX is loaded. The next enabled edge wraps straight to 0; there is no counting through the values above MAX.
  - en=0, ld=0: out holds.
- tc = en & (out >= MAX). It is high during the cycle in which the next edge will wrap.
  - Cascade: feed the low stage's tc into the next stage's en.
- ovf:
  - Set on any wrap.
  - Cleared when clr_ovf=1.
  - If a wrap and clr_ovf=1 occur on the same edge, the set wins and ovf=1.
  - rst clears ovf.
- Reset mid-count: out goes to 0 on that edge. tc falls combinationally once out=0, or immediately if en drops.
- Width rules:
  - Increment is modulo 2^WIDTH internally.
  - When MAX = 2^WIDTH-1, the natural rollover and the MAX wrap coincide; set ovf once per wrap.
  - No X-propagation: all outputs are defined from the first reset onward.
- Implementation structure:
  - The next-state function is expressed as per-bit toggle equations. Bit i toggles when en is high and bits 0..i-1 are all 1, unless the wrap condition is true, in which case every bit goes to 0.
  - The comparison against MAX is combinational decode of out against the constant.

Decomposition:
- Shared package, counter_pkg:
  - Default WIDTH constant.
  - Localparam helper for the all-ones value.
  - Common reset-value constant (0).
- One sub-module, up_count_slice:
  - Contains one bit of state with synchronous active-high reset, plus mux inputs load_bit, toggle and wrap.
  - Drives q.
  - Instantiated WIDTH times with a generate loop.
- The terminal decode and the ovf register stay in the top module.

Test Plan:
- Reset then count (WIDTH=4, MAX=15): rst=1 for 2 cycles, then en=1 for 17 cycles -> out 0,1,...,15,0,1. tc=1 only while out=15. ovf rises the cycle after the 15->0 edge and stays 1.
- Custom modulus (MAX=9): en=1 from reset -> out 0..9,0. tc=1 while out=9. ovf=1 after the first wrap.
- Load priority (MAX=9): at out=3 drive ld=1, d=7, en=1 -> out=7 next cycle, no increment. Load d=12 (above MAX), then en=1 -> out 12 then 0, ovf=1, tc=1 during out=12.
- Enable gating: en=0 for 5 cycles at out=6 -> out holds 6 and tc=0. Then en=1 -> out=7.
- ovf clear collision (MAX=15): out=15, en=1, clr_ovf=1 on the same edge -> out=0, ovf=1. Next cycle clr_ovf=1, en=0 -> ovf=0.
- Reset mid-operation: at out=11 assert rst together with ld=1, d=5, en=1 -> out=0 and ovf=0 on that edge; rst overrides the load.
